// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl
// Owns the single byte-wide RAM port that instruction fetch (IF) and data
// access (MEM) share. Each request is split into one byte beat per cycle.
// The block also drives the hazard stall vector for the pipeline registers
// and the PC hold.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   rdy               global enable; 0 freezes all sequencing
//   if_req/if_addr    fetch request (always 4 bytes) -> if_done/if_inst
//   mem_req/mem_we/mem_len/mem_addr/mem_wdata
//                     data access (1, 2 or 4 bytes) -> mem_done/mem_rdata
//   id_stall_req      load-use hazard from ID
//   jump_enable       taken branch/jump; kills an in-progress fetch
//   ram_a/ram_dout/ram_wr/ram_din
//                     byte RAM port; read data returns one cycle after ram_a
//   stall_ctrler      per-register hold vector (bit0 IF_ID .. bit3 MEM_WB)
//   pc_stall          hold PC
module mem_stall_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic               if_done,
  output logic [31:0]        if_inst,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [2:0]         mem_len,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [31:0]        mem_wdata,
  output logic               mem_done,
  output logic [31:0]        mem_rdata,
  input  logic               id_stall_req,
  input  logic               jump_enable,
  output logic [ADDR_W-1:0]  ram_a,
  output logic [7:0]         ram_dout,
  output logic               ram_wr,
  input  logic [7:0]         ram_din,
  output logic [STALL_W-1:0] stall_ctrler,
  output logic               pc_stall
);

  typedef enum logic [2:0] {IDLE, IF_XFER, MEM_RD, MEM_WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        len_q, len_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        beat_q, beat_d;
  logic              is_if_q, is_if_d;
  logic              we_q, we_d;
  logic              skip_if_q, skip_if_d;
  logic              accept;
  logic              last_beat;
  logic [2:0]        norm_len;

  // Read return tracking: which lane the address issued last cycle belongs to.
  logic              rd_vld_q;
  logic [1:0]        rd_lane_q;
  logic [31:0]       data_q;
  logic [31:0]       inst_q, rdata_q;
  logic [31:0]       word;
  logic              reading;

  assign reading   = (state_q == IF_XFER) || (state_q == MEM_RD);
  assign last_beat = ({1'b0, beat_q} == (len_q - 3'd1));
  assign norm_len  = (mem_len == 3'd1) ? 3'd1 :
                     (mem_len == 3'd2) ? 3'd2 : 3'd4;

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    wdata_d   = wdata_q;
    beat_d    = beat_q;
    is_if_d   = is_if_q;
    we_d      = we_q;
    skip_if_d = skip_if_q;
    accept    = 1'b0;
    if (rdy) begin
      skip_if_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_req) begin
            accept  = 1'b1;
            addr_d  = mem_addr;
            len_d   = norm_len;
            wdata_d = mem_wdata;
            is_if_d = 1'b0;
            we_d    = mem_we;
            beat_d  = 2'd0;
            state_d = mem_we ? MEM_WR : MEM_RD;
          end else if (if_req && !skip_if_q) begin
            // The fetch address in the cycle right after a jump abort is
            // still the stale one, so that cycle is skipped.
            accept  = 1'b1;
            addr_d  = if_addr;
            len_d   = 3'd4;
            wdata_d = '0;
            is_if_d = 1'b1;
            we_d    = 1'b0;
            beat_d  = 2'd0;
            state_d = IF_XFER;
          end
        end
        IF_XFER: begin
          if (jump_enable) begin
            state_d   = IDLE;
            beat_d    = 2'd0;
            skip_if_d = 1'b1;
          end else if (last_beat) begin
            state_d = DONE;
            beat_d  = 2'd0;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
        MEM_RD, MEM_WR: begin
          if (last_beat) begin
            state_d = DONE;
            beat_d  = 2'd0;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= 3'd0;
      wdata_q   <= '0;
      beat_q    <= 2'd0;
      is_if_q   <= 1'b0;
      we_q      <= 1'b0;
      skip_if_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_lane_q <= 2'd0;
      data_q    <= '0;
      inst_q    <= '0;
      rdata_q   <= '0;
    end else begin
      // The RAM read pipe runs even when rdy=0: while frozen the address is
      // held, so re-capturing the same lane stores the same byte again. This
      // keeps the byte that was in flight when rdy dropped.
      rd_vld_q  <= reading;
      rd_lane_q <= beat_q;
      if (accept)
        data_q <= '0;
      else if (rd_vld_q)
        data_q[{rd_lane_q, 3'b000} +: 8] <= ram_din;
      if (rdy) begin
        state_q   <= state_d;
        addr_q    <= addr_d;
        len_q     <= len_d;
        wdata_q   <= wdata_d;
        beat_q    <= beat_d;
        is_if_q   <= is_if_d;
        we_q      <= we_d;
        skip_if_q <= skip_if_d;
        if (state_q == DONE && !we_q) begin
          if (is_if_q) inst_q  <= word;
          else         rdata_q <= word;
        end
      end
    end
  end

  // The last byte arrives during the done cycle, so it is merged in directly.
  always_comb begin
    word = data_q;
    if (rd_vld_q) word[{rd_lane_q, 3'b000} +: 8] = ram_din;
  end

  assign if_done   = (state_q == DONE) && is_if_q;
  assign mem_done  = (state_q == DONE) && !is_if_q;
  assign if_inst   = if_done ? word : inst_q;
  assign mem_rdata = (mem_done && !we_q) ? word : rdata_q;

  assign ram_a    = (state_q == IF_XFER || state_q == MEM_RD || state_q == MEM_WR)
                    ? addr_q + ADDR_W'(beat_q) : '0;
  assign ram_wr   = (state_q == MEM_WR) && rdy;
  assign ram_dout = (state_q == MEM_WR) ? wdata_q[{beat_q, 3'b000} +: 8] : 8'h00;

  // Stall vector: the highest stage with an outstanding need wins. A done
  // pulse releases that requester's stall in the same cycle.
  always_comb begin
    stall_ctrler = '0;
    pc_stall     = 1'b0;
    if (mem_req && !mem_done) begin
      stall_ctrler[3:0] = 4'b1111;
      pc_stall          = 1'b1;
    end else if (id_stall_req) begin
      stall_ctrler[1:0] = 2'b11;
      pc_stall          = 1'b1;
    end else if (if_req && !if_done && !jump_enable) begin
      stall_ctrler[0] = 1'b1;
      pc_stall        = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
module tb_mem_stall_ctrl;
  logic        clk = 1'b0;
  logic        rst, rdy, if_req, mem_req, mem_we, id_stall_req, jump_enable;
  logic [31:0] if_addr, mem_addr, mem_wdata, if_inst, mem_rdata, ram_a;
  logic [2:0]  mem_len;
  logic        if_done, mem_done, ram_wr, pc_stall;
  logic [7:0]  ram_dout, ram_din;
  logic [4:0]  stall_ctrler;

  logic [7:0]  ram     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  int nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  mem_stall_ctrl #(.ADDR_W(32), .STALL_W(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .id_stall_req(id_stall_req), .jump_enable(jump_enable),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din),
    .stall_ctrler(stall_ctrler), .pc_stall(pc_stall)
  );

  // Byte RAM, one-cycle read latency (low 16 address bits decoded).
  always @(posedge clk) begin
    if (ram_wr) ram[ram_a[15:0]] = ram_dout;
    ram_din <= ram[ram_a[15:0]];
  end

  // Expected {pc_stall, stall_ctrler} from the priority rules.
  function automatic logic [5:0] exp_stall(input logic mreq, mdone, idst, ireq, idone, jmp);
    if (mreq && !mdone) return 6'b1_01111;
    if (idst)           return 6'b1_00011;
    if (ireq && !idone && !jmp) return 6'b1_00001;
    return 6'b0_00000;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int len);
    logic [31:0] w, t;
    w = '0;
    for (int j = 0; j < len; j++) begin
      t = a + 32'(j);
      w[8*j +: 8] = ref_mem[t[15:0]];
    end
    return w;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a[15:0]] = b;
    ref_mem[a[15:0]] = b;
  endtask

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic mid(); @(negedge clk); endtask

  task automatic quiet();
    if_req = 0; mem_req = 0; mem_we = 0; mem_len = 3'd4; id_stall_req = 0; jump_enable = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1; rdy = 1; quiet();
    cyc(); cyc(); mid();
    nchk++; if (if_done !== 1'b0) begin nerr++; $display("FAIL reset_if_done: got %b exp 0", if_done); end
    nchk++; if (mem_done !== 1'b0) begin nerr++; $display("FAIL reset_mem_done: got %b exp 0", mem_done); end
    nchk++; if (ram_wr !== 1'b0) begin nerr++; $display("FAIL reset_ram_wr: got %b exp 0", ram_wr); end
    nchk++; if (ram_a !== 32'h0) begin nerr++; $display("FAIL reset_ram_a: got %h exp 0", ram_a); end
    nchk++; if (if_inst !== 32'h0) begin nerr++; $display("FAIL reset_if_inst: got %h exp 0", if_inst); end
    nchk++; if (mem_rdata !== 32'h0) begin nerr++; $display("FAIL reset_mem_rdata: got %h exp 0", mem_rdata); end
    nchk++; if ({pc_stall, stall_ctrler} !== 6'b0) begin nerr++; $display("FAIL reset_stall: got %b exp 000000", {pc_stall, stall_ctrler}); end
    cyc(); rst = 0;
  endtask

  task automatic test_if_fetch();
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
    cyc(); quiet(); if_req = 1; if_addr = 32'h100; mid();
    nchk++; if ({pc_stall, stall_ctrler} !== 6'b1_00001) begin nerr++; $display("FAIL fetch_stall_req: got %b exp 100001", {pc_stall, stall_ctrler}); end
    for (int k = 0; k < 4; k++) begin
      cyc(); mid();
      nchk++; if (ram_a !== 32'h100 + 32'(k)) begin nerr++; $display("FAIL fetch_ram_a beat %0d: got %h exp %h", k, ram_a, 32'h100 + 32'(k)); end
      nchk++; if (if_done !== 1'b0) begin nerr++; $display("FAIL fetch_early_done beat %0d: got %b exp 0", k, if_done); end
      nchk++; if ({pc_stall, stall_ctrler} !== 6'b1_00001) begin nerr++; $display("FAIL fetch_stall beat %0d: got %b exp 100001", k, {pc_stall, stall_ctrler}); end
    end
    cyc(); mid();
    nchk++; if (if_done !== 1'b1) begin nerr++; $display("FAIL fetch_done: got %b exp 1", if_done); end
    nchk++; if (if_inst !== 32'h00000513) begin nerr++; $display("FAIL fetch_inst: got %h exp 00000513", if_inst); end
    nchk++; if ({pc_stall, stall_ctrler} !== 6'b0) begin nerr++; $display("FAIL fetch_stall_release: got %b exp 000000", {pc_stall, stall_ctrler}); end
    cyc(); quiet(); mid();
    nchk++; if (if_done !== 1'b0) begin nerr++; $display("FAIL fetch_done_pulse: got %b exp 0", if_done); end
  endtask

  task automatic test_arbitration();
    poke(32'h2000, 8'hEF); poke(32'h2001, 8'hBE);
    cyc(); quiet(); mem_req = 1; mem_we = 0; mem_len = 3'd2; mem_addr = 32'h2000;
    if_req = 1; if_addr = 32'h100; mid();
    nchk++; if ({pc_stall, stall_ctrler} !== 6'b1_01111) begin nerr++; $display("FAIL arb_stall_req: got %b exp 101111", {pc_stall, stall_ctrler}); end
    for (int k = 0; k < 2; k++) begin
      cyc(); mid();
      nchk++; if (ram_a !== 32'h2000 + 32'(k)) begin nerr++; $display("FAIL arb_mem_ram_a beat %0d: got %h exp %h", k, ram_a, 32'h2000 + 32'(k)); end
      nchk++; if ({pc_stall, stall_ctrler} !== 6'b1_01111) begin nerr++; $display("FAIL arb_mem_stall beat %0d: got %b exp 101111", k, {pc_stall, stall_ctrler}); end
    end
    cyc(); mid();
    nchk++; if (mem_done !== 1'b1) begin nerr++; $display("FAIL arb_mem_done: got %b exp 1", mem_done); end
    nchk++; if (mem_rdata !== 32'h0000BEEF) begin nerr++; $display("FAIL arb_mem_rdata: got %h exp 0000beef", mem_rdata); end
    nchk++; if ({pc_stall, stall_ctrler} !== 6'b1_00001) begin nerr++; $display("FAIL arb_done_stall: got %b exp 100001", {pc_stall, stall_ctrler}); end
    cyc(); mem_req = 0; mid();
    nchk++; if (if_done !== 1'b0) begin nerr++; $display("FAIL arb_idle_if_done: got %b exp 0", if_done); end
    for (int k = 0; k < 4; k++) begin
      cyc(); mid();
      nchk++; if (ram_a !== 32'h100 + 32'(k)) begin nerr++; $display("FAIL arb_if_ram_a beat %0d: got %h exp %h", k, ram_a, 32'h100 + 32'(k)); end
    end
    cyc(); mid();
    nchk++; if (if_done !== 1'b1 || if_inst !== 32'h00000513) begin nerr++; $display("FAIL arb_if_done: got done=%b inst=%h exp done=1 inst=00000513", if_done, if_inst); end
  endtask

  task automatic test_store();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    cyc(); quiet(); mem_req = 1; mem_we = 1; mem_len = 3'd4; mem_addr = 32'h3000; mem_wdata = 32'hDEADBEEF; mid();
    nchk++; if (ram_wr !== 1'b0) begin nerr++; $display("FAIL store_wr_before: got %b exp 0", ram_wr); end
    for (int k = 0; k < 4; k++) begin
      cyc(); mid();
      nchk++; if (ram_wr !== 1'b1 || ram_a !== 32'h3000 + 32'(k) || ram_dout !== exp_b[k]) begin
        nerr++; $display("FAIL store_beat %0d: got wr=%b a=%h d=%h exp wr=1 a=%h d=%h", k, ram_wr, ram_a, ram_dout, 32'h3000 + 32'(k), exp_b[k]); end
      nchk++; if (mem_done !== 1'b0) begin nerr++; $display("FAIL store_early_done beat %0d: got %b exp 0", k, mem_done); end
    end
    cyc(); mid();
    nchk++; if (mem_done !== 1'b1 || ram_wr !== 1'b0) begin nerr++; $display("FAIL store_done: got done=%b wr=%b exp done=1 wr=0", mem_done, ram_wr); end
    for (int k = 0; k < 4; k++) begin
      nchk++; if (ram[16'h3000 + 16'(k)] !== exp_b[k]) begin nerr++; $display("FAIL store_ram_byte %0d: got %h exp %h", k, ram[16'h3000 + 16'(k)], exp_b[k]); end
      ref_mem[16'h3000 + 16'(k)] = exp_b[k];
    end
  endtask

  task automatic test_jump();
    logic [31:0] expw;
    expw = ref_word(32'h500, 4);
    cyc(); quiet(); if_req = 1; if_addr = 32'h400; mid();
    cyc(); mid();
    nchk++; if (ram_a !== 32'h400) begin nerr++; $display("FAIL jump_beat0: got %h exp 00000400", ram_a); end
    cyc(); jump_enable = 1; if_addr = 32'h500; mid();
    nchk++; if (ram_a !== 32'h401) begin nerr++; $display("FAIL jump_beat1: got %h exp 00000401", ram_a); end
    nchk++; if ({pc_stall, stall_ctrler} !== exp_stall(0, 0, 0, 1, 0, 1)) begin nerr++; $display("FAIL jump_stall: got %b exp 000000", {pc_stall, stall_ctrler}); end
    cyc(); jump_enable = 0; mid();
    nchk++; if (if_done !== 1'b0) begin nerr++; $display("FAIL jump_no_done0: got %b exp 0", if_done); end
    cyc(); mid();
    nchk++; if (if_done !== 1'b0) begin nerr++; $display("FAIL jump_no_done1: got %b exp 0", if_done); end
    for (int k = 0; k < 4; k++) begin
      cyc(); mid();
      nchk++; if (ram_a !== 32'h500 + 32'(k)) begin nerr++; $display("FAIL jump_refetch beat %0d: got %h exp %h", k, ram_a, 32'h500 + 32'(k)); end
    end
    cyc(); mid();
    nchk++; if (if_done !== 1'b1 || if_inst !== expw) begin nerr++; $display("FAIL jump_refetch_done: got done=%b inst=%h exp done=1 inst=%h", if_done, if_inst, expw); end
  endtask

  // rdy=0 keeps the FSM idle so every input combination can be applied.
  task automatic test_stall_matrix();
    logic [3:0] m;
    cyc(); quiet(); rdy = 0;
    for (int i = 0; i < 16; i++) begin
      m = 4'(i);
      mem_req = m[3]; id_stall_req = m[2]; if_req = m[1]; jump_enable = m[0];
      #1;
      nchk++; if ({pc_stall, stall_ctrler} !== exp_stall(m[3], 0, m[2], m[1], 0, m[0])) begin
        nerr++; $display("FAIL stall_matrix %b: got %b exp %b", m, {pc_stall, stall_ctrler}, exp_stall(m[3], 0, m[2], m[1], 0, m[0])); end
    end
    mid();
    nchk++; if (ram_wr !== 1'b0) begin nerr++; $display("FAIL stall_matrix_wr: got %b exp 0", ram_wr); end
    cyc(); quiet(); rdy = 1;
  endtask

  task automatic test_reset_rdy();
    logic [31:0] expw;
    expw = ref_word(32'h700, 4);
    cyc(); quiet(); mem_req = 1; mem_len = 3'd4; mem_addr = 32'h600; mid();
    cyc(); mid();
    cyc(); mid();
    nchk++; if (ram_a !== 32'h601) begin nerr++; $display("FAIL rst_pre_beat1: got %h exp 00000601", ram_a); end
    cyc(); rst = 1; mem_req = 0; mid();
    cyc(); rst = 0; mid();
    nchk++; if (ram_a !== 32'h0 || ram_wr !== 1'b0) begin nerr++; $display("FAIL rst_mid_port: got a=%h wr=%b exp a=0 wr=0", ram_a, ram_wr); end
    nchk++; if (mem_rdata !== 32'h0 || if_inst !== 32'h0) begin nerr++; $display("FAIL rst_mid_data: got rdata=%h inst=%h exp 0 0", mem_rdata, if_inst); end
    for (int i = 0; i < 4; i++) begin
      nchk++; if (mem_done !== 1'b0) begin nerr++; $display("FAIL rst_no_done %0d: got %b exp 0", i, mem_done); end
      cyc(); mid();
    end
    cyc(); if_req = 1; if_addr = 32'h700; mid();
    cyc(); mid();
    nchk++; if (ram_a !== 32'h700) begin nerr++; $display("FAIL rdy_beat0: got %h exp 00000700", ram_a); end
    cyc(); rdy = 0; mid();
    for (int i = 0; i < 3; i++) begin
      nchk++; if (ram_a !== 32'h701 || if_done !== 1'b0) begin nerr++; $display("FAIL rdy_frozen %0d: got a=%h done=%b exp a=00000701 done=0", i, ram_a, if_done); end
      nchk++; if ({pc_stall, stall_ctrler} !== 6'b1_00001) begin nerr++; $display("FAIL rdy_frozen_stall %0d: got %b exp 100001", i, {pc_stall, stall_ctrler}); end
      cyc(); if (i == 2) rdy = 1; mid();
    end
    for (int k = 1; k < 4; k++) begin
      nchk++; if (ram_a !== 32'h700 + 32'(k)) begin nerr++; $display("FAIL rdy_resume beat %0d: got %h exp %h", k, ram_a, 32'h700 + 32'(k)); end
      cyc(); mid();
    end
    nchk++; if (if_done !== 1'b1 || if_inst !== expw) begin nerr++; $display("FAIL rdy_resume_done: got done=%b inst=%h exp done=1 inst=%h", if_done, if_inst, expw); end
  endtask

  // Random loads, stores and fetches with random rdy and id_stall_req. The
  // model: one beat per enabled cycle after acceptance, then one done cycle.
  task automatic test_random();
    logic        is_if, we, dn;
    logic [2:0]  lc;
    logic [31:0] a, wd, expw, t, got;
    int          len, k, budget;
    for (int n = 0; n < 40; n++) begin
      is_if = ($urandom_range(0, 2) == 0);
      we    = !is_if && ($urandom_range(0, 1) == 1);
      lc    = 3'($urandom_range(0, 7));
      len   = is_if ? 4 : (lc == 3'd1 ? 1 : (lc == 3'd2 ? 2 : 4));
      a     = (n == 5) ? 32'hFFFF_FFFE : {16'h0, 16'($urandom)};
      wd    = $urandom;
      expw  = ref_word(a, len);
      cyc(); quiet();
      rdy = ($urandom_range(0, 3) != 0); id_stall_req = 1'($urandom_range(0, 1));
      if (is_if) begin if_req = 1; if_addr = a; end
      else begin mem_req = 1; mem_we = we; mem_len = lc; mem_addr = a; mem_wdata = wd; end
      k = -1;
      for (budget = 0; budget < 200; budget++) begin
        mid();
        dn  = is_if ? if_done : mem_done;
        got = is_if ? if_inst : mem_rdata;
        if (k < len) begin
          nchk++; if (dn !== 1'b0) begin nerr++; $display("FAIL rnd%0d_early_done k=%0d: got %b exp 0", n, k, dn); end
        end
        if (k >= 0 && k < len) begin
          nchk++; if (ram_a !== a + 32'(k) || ram_wr !== (we && rdy)) begin
            nerr++; $display("FAIL rnd%0d_beat %0d: got a=%h wr=%b exp a=%h wr=%b", n, k, ram_a, ram_wr, a + 32'(k), we && rdy); end
          if (we) begin
            nchk++; if (ram_dout !== wd[8*k +: 8]) begin nerr++; $display("FAIL rnd%0d_dout %0d: got %h exp %h", n, k, ram_dout, wd[8*k +: 8]); end
          end
        end
        if (k == len) begin
          nchk++; if (dn !== 1'b1) begin nerr++; $display("FAIL rnd%0d_done: got %b exp 1", n, dn); end
          if (!we) begin
            nchk++; if (got !== expw) begin nerr++; $display("FAIL rnd%0d_data: got %h exp %h", n, got, expw); end
          end
        end
        nchk++; if ({pc_stall, stall_ctrler} !== exp_stall(mem_req, !is_if && k == len, id_stall_req, if_req, is_if && k == len, 1'b0)) begin
          nerr++; $display("FAIL rnd%0d_stall k=%0d: got %b exp %b", n, k, {pc_stall, stall_ctrler},
                           exp_stall(mem_req, !is_if && k == len, id_stall_req, if_req, is_if && k == len, 1'b0)); end
        if (rdy) begin
          if (k == len) break;
          k++;
        end
        cyc(); rdy = ($urandom_range(0, 3) != 0); id_stall_req = 1'($urandom_range(0, 1));
      end
      if (budget >= 200) begin
        nchk++; nerr++; $display("FAIL rnd%0d_timeout: got no done exp done within 200 cycles", n);
        rst = 1; quiet(); rdy = 1; cyc(); cyc(); rst = 0;
      end else if (we) begin
        for (int j = 0; j < len; j++) begin
          t = a + 32'(j);
          ref_mem[t[15:0]] = wd[8*j +: 8];
          nchk++; if (ram[t[15:0]] !== ref_mem[t[15:0]]) begin nerr++; $display("FAIL rnd%0d_ram %h: got %h exp %h", n, t, ram[t[15:0]], ref_mem[t[15:0]]); end
        end
      end
    end
    cyc(); quiet(); rdy = 1;
  endtask

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 65536; i++) begin
      b = 8'($urandom);
      ram[i] = b;
      ref_mem[i] = b;
    end
    test_reset();
    test_if_fetch();
    test_arbitration();
    test_store();
    test_jump();
    test_stall_matrix();
    test_reset_rdy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
